i2c_eeprom_target: RTL and testbench

- Serial memory target sitting directly downstream of the team's I2C EEPROM master. It consumes the master's scl/sda and returns the master's ack input.
- Holds a 128 x 8 byte array addressed by the 7-bit address field of the frame.
- Write frame: stores the data byte. Read frame: drives the stored byte back onto sda.
- All bus sampling is done in the system clk domain (oversampled; clk is at least 8x scl).

---
 rtl/i2c_eeprom_target.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_eeprom_target.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_target.sv
// i2c_eeprom_target: oversampled serial byte-memory target for the I2C EEPROM master.
// Frames are LSB first: START, header {addr[6:0], wr}, ack slot, data byte, ack slot, STOP.
// Bus bits are taken on scl falling edges seen in the clk domain.
module i2c_eeprom_target #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MEM_DEPTH   = 128,
  parameter logic [7:0]  RESET_BYTE  = 8'h00
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  inout  wire  sda,
  output logic ack,
  output logic busy,
  output logic wr_done,
  output logic frame_err
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] HDR       = 3'd1;
  localparam logic [2:0] HDR_ACK   = 3'd2;
  localparam logic [2:0] WDATA     = 3'd3;
  localparam logic [2:0] WDATA_ACK = 3'd4;
  localparam logic [2:0] RDATA     = 3'd5;
  localparam logic [2:0] WAIT_STOP = 3'd6;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_q;
  logic                   sda_q;

  logic                   sclr;
  logic                   sclf;
  logic                   start_det;
  logic                   stop_det;
  logic                   bit_evt;

  logic [2:0]             state;
  logic [2:0]             bit_cnt;
  logic [2:0]             next_cnt;
  logic [7:0]             shreg;
  logic [7:0]             shifted;
  logic                   wr_flag;
  logic [6:0]             addr;
  logic [IDX_W-1:0]       idx;
  logic [7:0]             rd_byte;
  logic                   mem_we;
  logic                   sda_oe;
  logic                   sda_out;
  logic                   rise_seen;

  logic [7:0]             mem [MEM_DEPTH];

  // The target only ever drives the line while presenting read data.
  assign sda = sda_oe ? sda_out : 1'bz;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Synchronize scl/sda into clk and keep one previous sample for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  // Bus events, shift value, array addressing and write enable.
  always_comb begin
    sclr      = ~scl_q & scl_s;
    sclf      = scl_q & ~scl_s;
    start_det = scl_q & scl_s & sda_q & ~sda_s;
    stop_det  = scl_q & scl_s & ~sda_q & sda_s;
    // A START/STOP in the same clk as a falling scl discards that bit.
    bit_evt   = sclf & rise_seen & ~start_det & ~stop_det;
    shifted   = {sda_s, shreg[7:1]};
    next_cnt  = bit_cnt + 3'd1;
    idx       = IDX_W'(32'(addr) % MEM_DEPTH);
    rd_byte   = mem[idx];
    mem_we    = bit_evt & (state == WDATA) & (bit_cnt == 3'd7);
  end

  // Byte array: reloaded with RESET_BYTE on reset, written once per write frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem[IDX_W'(i)] <= RESET_BYTE;
      end
    end else if (mem_we) begin
      mem[idx] <= shifted;
    end
  end

  // Frame sequencer: START/STOP handling has priority over bit processing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      wr_flag   <= 1'b0;
      addr      <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      wr_done   <= 1'b0;
      frame_err <= 1'b0;
      sda_oe    <= 1'b0;
      sda_out   <= 1'b0;
      rise_seen <= 1'b0;
    end else begin
      wr_done   <= 1'b0;
      frame_err <= 1'b0;
      if (sclr) begin
        rise_seen <= 1'b1;
      end

      if (start_det) begin
        if ((state != IDLE) && (state != WAIT_STOP)) begin
          frame_err <= 1'b1;
        end
        state     <= HDR;
        busy      <= 1'b1;
        bit_cnt   <= '0;
        ack       <= 1'b0;
        sda_oe    <= 1'b0;
        // The scl fall that closes the START condition carries no data bit;
        // only falls preceded by a rise inside the frame are sampled.
        rise_seen <= 1'b0;
      end else if (stop_det) begin
        if (state != IDLE) begin
          // A header without its data byte is treated as malformed as well.
          if ((state == HDR) || (state == HDR_ACK) ||
              (state == WDATA) || (state == RDATA)) begin
            frame_err <= 1'b1;
          end
          state  <= IDLE;
          busy   <= 1'b0;
          ack    <= 1'b0;
          sda_oe <= 1'b0;
        end
      end else if (bit_evt) begin
        case (state)
          HDR: begin
            shreg   <= shifted;
            bit_cnt <= next_cnt;
            if (bit_cnt == 3'd7) begin
              wr_flag <= shifted[0];
              addr    <= shifted[7:1];
              ack     <= 1'b1;
              state   <= HDR_ACK;
            end
          end
          HDR_ACK: begin
            ack     <= 1'b0;
            bit_cnt <= '0;
            if (wr_flag) begin
              state <= WDATA;
            end else begin
              state   <= RDATA;
              sda_oe  <= 1'b1;
              sda_out <= rd_byte[0];
            end
          end
          WDATA: begin
            shreg   <= shifted;
            bit_cnt <= next_cnt;
            if (bit_cnt == 3'd7) begin
              wr_done <= 1'b1;
              ack     <= 1'b1;
              state   <= WDATA_ACK;
            end
          end
          WDATA_ACK: begin
            ack   <= 1'b0;
            state <= WAIT_STOP;
          end
          RDATA: begin
            if (bit_cnt == 3'd7) begin
              sda_oe <= 1'b0;
              state  <= WAIT_STOP;
            end else begin
              sda_out <= rd_byte[next_cnt];
              bit_cnt <= next_cnt;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// tb_i2c_eeprom_target: drives master-side frames and checks against a byte-array model.
module tb_i2c_eeprom_target;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic scl   = 1'b1;
  logic m_en  = 1'b1;
  logic m_val = 1'b1;
  wire  sda;
  logic ack;
  logic busy;
  logic wr_done;
  logic frame_err;

  int checks        = 0;
  int failures      = 0;
  int wr_done_cnt   = 0;
  int frame_err_cnt = 0;

  logic [7:0] model_mem [128];

  assign sda = m_en ? m_val : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_eeprom_target #(
    .SYNC_STAGES(2),
    .MEM_DEPTH  (128),
    .RESET_BYTE (8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .ack      (ack),
    .busy     (busy),
    .wr_done  (wr_done),
    .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (wr_done === 1'b1) wr_done_cnt++;
    if (frame_err === 1'b1) frame_err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- master-side bus sequences ----------------
  task automatic phase();
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_start();
    m_en = 1'b1; m_val = 1'b1; phase();
    scl = 1'b1; phase();
    m_val = 1'b0; phase();
    scl = 1'b0; phase();
  endtask

  task automatic bus_stop();
    m_en = 1'b1; m_val = 1'b0; phase();
    scl = 1'b1; phase();
    m_val = 1'b1; phase();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      m_en = 1'b1; m_val = b[i]; phase();
      scl = 1'b1; phase();
      scl = 1'b0; phase();
    end
  endtask

  task automatic ack_slot(output logic hi, output logic lo);
    m_en = 1'b0; phase();
    scl = 1'b1; phase();
    hi = ack;
    scl = 1'b0; phase();
    lo = ack;
  endtask

  task automatic recv_bits(input int n, output logic [7:0] b);
    b = 8'h00;
    m_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      phase();
      scl = 1'b1; phase();
      b[i] = sda;
      scl = 1'b0; phase();
    end
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, output logic acks_ok);
    logic h1, l1, h2, l2;
    bus_start();
    send_bits({a, 1'b1}, 8);
    ack_slot(h1, l1);
    send_bits(d, 8);
    ack_slot(h2, l2);
    bus_stop();
    acks_ok = h1 & ~l1 & h2 & ~l2;
  endtask

  task automatic do_read(input logic [6:0] a, output logic [7:0] d,
                         output logic oe_after, output logic hdr_ack);
    logic h, l;
    bus_start();
    send_bits({a, 1'b0}, 8);
    ack_slot(h, l);
    hdr_ack = h & ~l;
    recv_bits(8, d);
    oe_after = dut.sda_oe;
    // extra NACK clock, which the target ignores while waiting for STOP
    m_en = 1'b0; phase();
    scl = 1'b1; phase();
    scl = 1'b0; phase();
    bus_stop();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (wr_done !== 1'b0) begin failures++; $display("FAIL reset_wr_done: got %b expected 0", wr_done); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (dut.sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe: got %b expected 0", dut.sda_oe); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    phase();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_unwritten();
    logic [7:0] got; logic oe_after, hok; int fe0;
    fe0 = frame_err_cnt;
    do_read(7'h00, got, oe_after, hok);
    checks++; if (got !== model_mem[0]) begin failures++; $display("FAIL unwritten_data: got %h expected %h", got, model_mem[0]); end
    checks++; if (hok !== 1'b1) begin failures++; $display("FAIL unwritten_hdr_ack: got %b expected 1", hok); end
    checks++; if (frame_err_cnt - fe0 != 0) begin failures++; $display("FAIL unwritten_frame_err: got %0d expected 0", frame_err_cnt - fe0); end
  endtask

  task automatic test_write();
    logic h, l, dh, dl, oe_after, hok; logic [7:0] got; int wd0, fe0;
    wd0 = wr_done_cnt; fe0 = frame_err_cnt;
    bus_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy_start: got %b expected 1", busy); end
    send_bits({7'h15, 1'b1}, 8);
    ack_slot(h, l);
    checks++; if (h !== 1'b1 || l !== 1'b0) begin failures++; $display("FAIL write_hdr_ack: got %b%b expected 10", h, l); end
    send_bits(8'hA5, 8);
    ack_slot(dh, dl);
    checks++; if (dh !== 1'b1 || dl !== 1'b0) begin failures++; $display("FAIL write_data_ack: got %b%b expected 10", dh, dl); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy_pre_stop: got %b expected 1", busy); end
    bus_stop();
    model_mem[7'h15] = 8'hA5;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_stop: got %b expected 0", busy); end
    checks++; if (wr_done_cnt - wd0 != 1) begin failures++; $display("FAIL write_wr_done: got %0d expected 1", wr_done_cnt - wd0); end
    checks++; if (frame_err_cnt - fe0 != 0) begin failures++; $display("FAIL write_frame_err: got %0d expected 0", frame_err_cnt - fe0); end
    do_read(7'h15, got, oe_after, hok);
    checks++; if (got !== model_mem[7'h15]) begin failures++; $display("FAIL write_mem: got %h expected %h", got, model_mem[7'h15]); end
  endtask

  task automatic test_readback();
    logic ok, oe_after, hok; logic [7:0] got;
    do_write(7'h7F, 8'h3C, ok);
    model_mem[7'h7F] = 8'h3C;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL readback_write_acks: got %b expected 1", ok); end
    do_read(7'h7F, got, oe_after, hok);
    checks++; if (got !== model_mem[7'h7F]) begin failures++; $display("FAIL readback_data: got %h expected %h", got, model_mem[7'h7F]); end
    checks++; if (oe_after !== 1'b0) begin failures++; $display("FAIL readback_oe_release: got %b expected 0", oe_after); end
    checks++; if (hok !== 1'b1) begin failures++; $display("FAIL readback_hdr_ack: got %b expected 1", hok); end
  endtask

  task automatic test_abort();
    logic ok, h, l, oe_after, hok; logic [7:0] got; int wd0, fe0;
    do_write(7'h01, 8'h81, ok);
    model_mem[7'h01] = 8'h81;
    wd0 = wr_done_cnt; fe0 = frame_err_cnt;
    bus_start();
    send_bits({7'h01, 1'b1}, 8);
    ack_slot(h, l);
    send_bits(8'hFF, 4);
    bus_stop();
    checks++; if (frame_err_cnt - fe0 != 1) begin failures++; $display("FAIL abort_frame_err: got %0d expected 1", frame_err_cnt - fe0); end
    checks++; if (wr_done_cnt - wd0 != 0) begin failures++; $display("FAIL abort_wr_done: got %0d expected 0", wr_done_cnt - wd0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
    do_read(7'h01, got, oe_after, hok);
    checks++; if (got !== model_mem[7'h01]) begin failures++; $display("FAIL abort_mem: got %h expected %h", got, model_mem[7'h01]); end
  endtask

  task automatic test_repeated_start();
    logic h1, l1, h2, l2, oe_after, hok; logic [7:0] got; int wd0, fe0;
    wd0 = wr_done_cnt; fe0 = frame_err_cnt;
    bus_start();
    send_bits({7'h02, 1'b1}, 5);
    bus_start();
    send_bits({7'h02, 1'b1}, 8);
    ack_slot(h1, l1);
    send_bits(8'h5A, 8);
    ack_slot(h2, l2);
    bus_stop();
    model_mem[7'h02] = 8'h5A;
    checks++; if (frame_err_cnt - fe0 != 1) begin failures++; $display("FAIL rstart_frame_err: got %0d expected 1", frame_err_cnt - fe0); end
    checks++; if ({h1, l1, h2, l2} !== 4'b1010) begin failures++; $display("FAIL rstart_acks: got %b expected 1010", {h1, l1, h2, l2}); end
    checks++; if (wr_done_cnt - wd0 != 1) begin failures++; $display("FAIL rstart_wr_done: got %0d expected 1", wr_done_cnt - wd0); end
    do_read(7'h02, got, oe_after, hok);
    checks++; if (got !== model_mem[7'h02]) begin failures++; $display("FAIL rstart_mem: got %h expected %h", got, model_mem[7'h02]); end
  endtask

  task automatic test_random();
    logic [6:0] a; logic [7:0] d, got; logic ok, oe_after; int wd0, fe0, nw;
    wd0 = wr_done_cnt; fe0 = frame_err_cnt; nw = 0;
    for (int i = 0; i < 24; i++) begin
      a = 7'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        do_write(a, d, ok);
        model_mem[a] = d;
        nw++;
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL random_write_acks: addr %h got %b expected 1", a, ok); end
      end else begin
        do_read(a, got, oe_after, ok);
        checks++; if (got !== model_mem[a]) begin failures++; $display("FAIL random_read: addr %h got %h expected %h", a, got, model_mem[a]); end
      end
    end
    checks++; if (wr_done_cnt - wd0 != nw) begin failures++; $display("FAIL random_wr_done: got %0d expected %0d", wr_done_cnt - wd0, nw); end
    checks++; if (frame_err_cnt - fe0 != 0) begin failures++; $display("FAIL random_frame_err: got %0d expected 0", frame_err_cnt - fe0); end
  endtask

  task automatic test_reset_mid_read();
    logic ok, h, l, oe_after, hok; logic [7:0] part, got;
    do_write(7'h33, 8'hF7, ok);
    model_mem[7'h33] = 8'hF7;
    bus_start();
    send_bits({7'h33, 1'b0}, 8);
    ack_slot(h, l);
    recv_bits(3, part);
    checks++; if (part[2:0] !== 3'b111) begin failures++; $display("FAIL midread_bits: got %b expected 111", part[2:0]); end
    checks++; if (dut.sda_oe !== 1'b1 || sda !== 1'b0) begin failures++; $display("FAIL midread_bit3_driven: got oe=%b sda=%b expected oe=1 sda=0", dut.sda_oe, sda); end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (dut.sda_oe !== 1'b0 || sda !== 1'b1) begin failures++; $display("FAIL midread_release: got oe=%b sda=%b expected oe=0 sda=1", dut.sda_oe, sda); end
    checks++; if ({ack, busy, wr_done, frame_err} !== 4'b0000) begin failures++; $display("FAIL midread_outputs: got %b expected 0000", {ack, busy, wr_done, frame_err}); end
    scl = 1'b1; m_en = 1'b1; m_val = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    phase();
    do_read(7'h33, got, oe_after, hok);
    checks++; if (got !== model_mem[7'h33]) begin failures++; $display("FAIL midread_array_reinit: got %h expected %h", got, model_mem[7'h33]); end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_unwritten();
    test_write();
    test_readback();
    test_abort();
    test_repeated_start();
    test_random();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
